// File: rtl/rtc_timekeeper.sv
// Centisecond time-of-day keeper with 12/24-hour BCD display, time/alarm set
// modes, up/down auto-repeat and a self-clearing alarm.
module rtc_timekeeper #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int REPEAT_CYC    = 25_000_000,
    parameter int ALARM_SECS    = 60,
    parameter int ALARM_RST_HR  = 6,
    parameter int ALARM_RST_MIN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       center,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       fmt_24h,
    input  logic       alarm_en,
    output logic [7:0] d_csec,
    output logic [7:0] d_sec,
    output logic [7:0] d_min,
    output logic [7:0] d_hr,
    output logic       pm,
    output logic [1:0] mode,
    output logic       field_hr,
    output logic       alarm_hit,
    output logic       tick_cs
);
    localparam int DIV      = CLK_HZ / 100;
    localparam int PW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int RW       = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC + 1) : 1;
    localparam int ALARM_CS = (ALARM_SECS > 0) ? ALARM_SECS * 100 : 1;
    localparam int AW       = $clog2(ALARM_CS + 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_TIME = 2'd1, SET_ALARM = 2'd2} mode_t;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                             input logic inc);
        if (inc)
            return (v == top) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    mode_t          mode_reg, mode_next;
    logic [4:0]     btn, btn_prev_reg, btn_edge;
    logic [1:0]     held, step_ev;
    logic [4:0]     hr_reg, al_hr_reg;
    logic [5:0]     min_reg, sec_reg, al_min_reg;
    logic [6:0]     csec_reg;
    logic [PW-1:0]  presc_reg;
    logic           field_hr_reg, tick_reg, alarm_hit_reg;
    logic [AW-1:0]  al_cnt_reg;
    logic [7:0]     d_csec_reg, d_sec_reg, d_min_reg, d_hr_reg;
    logic           pm_reg;

    // Button order: {center, left, right, up, down}
    assign btn      = {center, left, right, up, down};
    assign btn_edge = btn & ~btn_prev_reg;
    assign held     = {up, down};

    always_ff @(posedge clk) begin
        if (rst)
            btn_prev_reg <= '0;
        else
            btn_prev_reg <= btn;
    end

    // Auto-repeat for up (gi=1) and down (gi=0); the count restarts on each edge.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rep
            logic [RW-1:0] rep_cnt_reg;
            logic          rep_fire;
            assign rep_fire = (REPEAT_CYC != 0) && held[gi] && !btn_edge[gi] &&
                              (rep_cnt_reg == RW'(REPEAT_CYC));
            always_ff @(posedge clk) begin
                if (rst || !held[gi])
                    rep_cnt_reg <= '0;
                else if (btn_edge[gi] || rep_fire)
                    rep_cnt_reg <= RW'(1);
                else if (rep_cnt_reg != RW'(REPEAT_CYC))
                    rep_cnt_reg <= rep_cnt_reg + 1'b1;
            end
            assign step_ev[gi] = btn_edge[gi] || rep_fire;
        end
    endgenerate

    logic c_ev, lr_ev, any_ev, inc, dec, edit;
    assign c_ev   = btn_edge[4];
    assign lr_ev  = btn_edge[3] | btn_edge[2];
    assign any_ev = (|btn_edge) | (|step_ev);
    assign inc    = step_ev[1] & ~step_ev[0];
    assign dec    = step_ev[0] & ~step_ev[1];
    assign edit   = inc | dec;

    always_ff @(posedge clk) begin
        if (rst)
            mode_reg <= SET_TIME;
        else
            mode_reg <= mode_next;
    end

    always_comb begin
        mode_next = mode_reg;
        if (c_ev) begin
            case (mode_reg)
                RUN:      mode_next = SET_TIME;
                SET_TIME: mode_next = SET_ALARM;
                default:  mode_next = RUN;
            endcase
        end
    end

    // A center event pre-empts editing and counting on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hr_reg       <= '0;
            min_reg      <= '0;
            sec_reg      <= '0;
            csec_reg     <= '0;
            al_hr_reg    <= 5'(ALARM_RST_HR);
            al_min_reg   <= 6'(ALARM_RST_MIN);
            presc_reg    <= '0;
            field_hr_reg <= 1'b0;
            tick_reg     <= 1'b0;
        end else if (c_ev) begin
            tick_reg <= 1'b0;
            if (mode_next == SET_TIME) begin
                csec_reg  <= '0;
                sec_reg   <= '0;
                presc_reg <= '0;
            end
            if (mode_next != RUN)
                field_hr_reg <= 1'b0;
        end else if (mode_reg != RUN) begin
            presc_reg <= '0;
            tick_reg  <= 1'b0;
            if (lr_ev)
                field_hr_reg <= ~field_hr_reg;
            if (edit) begin
                if (mode_reg == SET_TIME) begin
                    if (field_hr_reg)
                        hr_reg <= 5'(wrap_step({1'b0, hr_reg}, 6'd23, inc));
                    else
                        min_reg <= wrap_step(min_reg, 6'd59, inc);
                end else begin
                    if (field_hr_reg)
                        al_hr_reg <= 5'(wrap_step({1'b0, al_hr_reg}, 6'd23, inc));
                    else
                        al_min_reg <= wrap_step(al_min_reg, 6'd59, inc);
                end
            end
        end else if (presc_reg == PW'(DIV - 1)) begin
            presc_reg <= '0;
            tick_reg  <= 1'b1;
            if (csec_reg == 7'd99) begin
                csec_reg <= '0;
                if (sec_reg == 6'd59) begin
                    sec_reg <= '0;
                    if (min_reg == 6'd59) begin
                        min_reg <= '0;
                        hr_reg  <= (hr_reg == 5'd23) ? 5'd0 : hr_reg + 5'd1;
                    end else begin
                        min_reg <= min_reg + 6'd1;
                    end
                end else begin
                    sec_reg <= sec_reg + 6'd1;
                end
            end else begin
                csec_reg <= csec_reg + 7'd1;
            end
        end else begin
            presc_reg <= presc_reg + 1'b1;
            tick_reg  <= 1'b0;
        end
    end

    // tick_reg marks that the time registers just advanced, so an exact match
    // here means this tick reached the alarm time.
    logic trigger, clear;
    assign trigger = (mode_reg == RUN) && alarm_en && tick_reg &&
                     (hr_reg == al_hr_reg) && (min_reg == al_min_reg) &&
                     (sec_reg == 6'd0) && (csec_reg == 7'd0);
    assign clear   = any_ev || !alarm_en || (mode_reg != RUN) || (mode_next != RUN);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            alarm_hit_reg <= 1'b0;
            al_cnt_reg    <= '0;
        end else if (trigger) begin
            alarm_hit_reg <= 1'b1;
            al_cnt_reg    <= '0;
        end else if (alarm_hit_reg && tick_reg) begin
            if (al_cnt_reg == AW'(ALARM_CS - 1)) begin
                alarm_hit_reg <= 1'b0;
                al_cnt_reg    <= '0;
            end else begin
                al_cnt_reg <= al_cnt_reg + 1'b1;
            end
        end
    end

    logic [4:0] src_hr, hr12;
    logic [5:0] src_min, src_sec;
    logic [6:0] src_csec;
    always_comb begin
        src_hr   = hr_reg;
        src_min  = min_reg;
        src_sec  = sec_reg;
        src_csec = csec_reg;
        if (mode_reg == SET_ALARM) begin
            src_hr   = al_hr_reg;
            src_min  = al_min_reg;
            src_sec  = '0;
            src_csec = '0;
        end
        hr12 = src_hr;
        if (src_hr == 5'd0)
            hr12 = 5'd12;
        else if (src_hr > 5'd12)
            hr12 = src_hr - 5'd12;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_csec_reg <= '0;
            d_sec_reg  <= '0;
            d_min_reg  <= '0;
            d_hr_reg   <= fmt_24h ? 8'h00 : 8'h12;
            pm_reg     <= 1'b0;
        end else begin
            d_csec_reg <= to_bcd(src_csec);
            d_sec_reg  <= to_bcd(7'(src_sec));
            d_min_reg  <= to_bcd(7'(src_min));
            d_hr_reg   <= to_bcd(7'(fmt_24h ? src_hr : hr12));
            pm_reg     <= (src_hr >= 5'd12);
        end
    end

    assign d_csec    = d_csec_reg;
    assign d_sec     = d_sec_reg;
    assign d_min     = d_min_reg;
    assign d_hr      = d_hr_reg;
    assign pm        = pm_reg;
    assign mode      = mode_reg;
    assign field_hr  = field_hr_reg;
    assign alarm_hit = alarm_hit_reg;
    assign tick_cs   = tick_reg;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: a time-of-day model in centiseconds checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rtc_timekeeper;
    localparam int CLK_HZ = 200;
    localparam int DIV    = CLK_HZ / 100;
    localparam int REP    = 20;
    localparam int ASECS  = 60;
    localparam int DAY    = 8_640_000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic center = 1'b0, left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic fmt_24h = 1'b0, alarm_en = 1'b0;
    logic [7:0] d_csec, d_sec, d_min, d_hr;
    logic [1:0] mode;
    logic pm, field_hr, alarm_hit, tick_cs;

    int checks = 0;
    int failures = 0;

    rtc_timekeeper #(
        .CLK_HZ(CLK_HZ), .REPEAT_CYC(REP), .ALARM_SECS(ASECS),
        .ALARM_RST_HR(6), .ALARM_RST_MIN(0)
    ) dut (
        .clk(clk), .rst(rst), .center(center), .left(left), .right(right),
        .up(up), .down(down), .fmt_24h(fmt_24h), .alarm_en(alarm_en),
        .d_csec(d_csec), .d_sec(d_sec), .d_min(d_min), .d_hr(d_hr), .pm(pm),
        .mode(mode), .field_hr(field_hr), .alarm_hit(alarm_hit), .tick_cs(tick_cs)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // Model: time as centiseconds of day, alarm as minutes of day.
    int m_mode, m_tod, m_al, m_ph, m_start, m_hold_up, m_hold_dn;
    bit m_field, m_tick, m_hit, m_valid;
    bit [4:0] m_prev;
    logic [7:0] e_csec, e_sec, e_min, e_hr;
    bit e_pm;

    task automatic model_step();
        int h, mi, s, c, hd, step, old_mode, new_mode, elapsed;
        bit [4:0] btn, edg;
        bit up_ev, dn_ev, c_ev, lr_ev, any_ev, trig, old_tick;
        if (rst) begin
            m_valid = 1; m_mode = 1; m_field = 0; m_tod = 0; m_al = 6 * 60; m_ph = 0;
            m_tick = 0; m_hit = 0; m_start = 0; m_prev = '0; m_hold_up = 0; m_hold_dn = 0;
            e_csec = 0; e_sec = 0; e_min = 0; e_pm = 0;
            e_hr = fmt_24h ? 8'h00 : 8'h12;
            return;
        end
        if (m_mode == 2) begin
            h = m_al / 60; mi = m_al % 60; s = 0; c = 0;
        end else begin
            h = m_tod / 360000; mi = (m_tod / 6000) % 60; s = (m_tod / 100) % 60; c = m_tod % 100;
        end
        hd = fmt_24h ? h : ((h + 11) % 12) + 1;
        e_hr = bcd(hd); e_min = bcd(mi); e_sec = bcd(s); e_csec = bcd(c); e_pm = (h >= 12);

        btn = {center, left, right, up, down};
        edg = btn & ~m_prev;
        m_prev = btn;
        m_hold_up = up ? m_hold_up + 1 : 0;
        m_hold_dn = down ? m_hold_dn + 1 : 0;
        up_ev = up && ((m_hold_up - 1) % REP == 0);
        dn_ev = down && ((m_hold_dn - 1) % REP == 0);
        c_ev = edg[4];
        lr_ev = edg[3] | edg[2];
        any_ev = (edg != 0) || up_ev || dn_ev;

        old_mode = m_mode;
        old_tick = m_tick;
        new_mode = c_ev ? (old_mode + 1) % 3 : old_mode;
        trig = (old_mode == 0) && alarm_en && old_tick && (m_tod == m_al * 6000);
        elapsed = (m_tod - m_start + DAY) % DAY;
        if (any_ev || !alarm_en || old_mode != 0 || new_mode != 0)
            m_hit = 0;
        else if (trig) begin
            m_hit = 1; m_start = m_tod;
        end else if (m_hit && old_tick && elapsed >= ASECS * 100)
            m_hit = 0;

        m_tick = 0;
        if (c_ev) begin
            m_mode = new_mode;
            if (new_mode == 1) begin
                m_tod = m_tod - (m_tod % 6000); m_ph = 0;
            end
            if (new_mode != 0) m_field = 0;
        end else if (old_mode != 0) begin
            step = (up_ev && !dn_ev) ? 1 : ((dn_ev && !up_ev) ? -1 : 0);
            if (step != 0) begin
                if (old_mode == 1) begin
                    h = m_tod / 360000; mi = (m_tod / 6000) % 60;
                end else begin
                    h = m_al / 60; mi = m_al % 60;
                end
                if (m_field) h = (h + step + 24) % 24;
                else mi = (mi + step + 60) % 60;
                if (old_mode == 1) m_tod = h * 360000 + mi * 6000 + (m_tod % 6000);
                else m_al = h * 60 + mi;
            end
            if (lr_ev) m_field = !m_field;
        end else if (m_ph == DIV - 1) begin
            m_ph = 0; m_tick = 1; m_tod = (m_tod + 1) % DAY;
        end else begin
            m_ph++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid)
            chk("outputs", {d_csec, d_sec, d_min, d_hr, pm, mode, field_hr, alarm_hit, tick_cs},
                {e_csec, e_sec, e_min, e_hr, e_pm, 2'(m_mode), m_field, m_hit, m_tick});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: center = v;
            1: left = v;
            2: right = v;
            3: up = v;
            default: down = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1); cyc(1); set_btn(b, 1'b0); cyc(1);
    endtask

    task automatic press_n(input int b, input int n);
        repeat (n) press(b);
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int cnt = 0;
        while (seen < n && cnt < n * DIV * 2 + 20) begin
            cyc(1); cnt++;
            if (tick_cs) seen++;
        end
        chk("tick_count", 40'(seen), 40'(n));
    endtask

    initial begin
        int k;
        cyc(2);
        chk("rst_mode", 40'(mode), 40'd1);
        chk("rst_d_hr12", 40'(d_hr), 40'h12);
        chk("rst_alarm", 40'({alarm_hit, tick_cs, pm}), 40'd0);
        fmt_24h = 1; cyc(1);
        chk("rst_d_hr24", 40'(d_hr), 40'h00);
        fmt_24h = 0; rst = 0; cyc(1);

        press(0);
        chk("mode_set_alarm", 40'(mode), 40'd2);
        press(0);
        chk("mode_run", 40'(mode), 40'd0);
        wait_ticks(1);
        k = 0;
        do begin cyc(1); k++; end while (!tick_cs && k < 20);
        chk("tick_period", 40'(k), 40'(DIV));
        wait_ticks(98);
        cyc(1);
        chk("sec_after_100", 40'({d_sec, d_csec}), 40'h0100);

        press(0);                         // SET_TIME, minute field
        press(4);
        chk("min_down_wrap", 40'(d_min), 40'h59);
        press(3);
        chk("min_up_wrap", 40'({d_hr, d_min}), 40'h1200);
        up = 1; cyc(45); up = 0; cyc(2);
        chk("hold_up_45", 40'(d_min), 40'h03);
        up = 1; down = 1; cyc(1); up = 0; down = 0; cyc(2);
        chk("up_down_same", 40'(d_min), 40'h03);
        press(1);
        chk("field_hr", 40'(field_hr), 40'd1);
        press_n(3, 13);
        chk("hr13_12h", 40'({d_hr, pm}), 40'({8'h01, 1'b1}));
        fmt_24h = 1; cyc(1);
        chk("hr13_24h", 40'(d_hr), 40'h13);
        fmt_24h = 0;
        press_n(3, 10);
        press(2);
        press_n(4, 4);
        chk("time_2359", 40'({d_hr, d_min, pm}), 40'({8'h11, 8'h59, 1'b1}));

        press(0);                         // SET_ALARM
        fmt_24h = 1; cyc(1);
        chk("alarm_rst_disp", 40'({mode, d_hr, d_min, d_sec}), 40'({2'd2, 8'h06, 8'h00, 8'h00}));
        fmt_24h = 0;
        press(1);
        press_n(4, 6);
        chk("alarm_0000", 40'({d_hr, d_min, pm}), 40'({8'h12, 8'h00, 1'b0}));
        alarm_en = 1;
        press(0);                         // RUN from 23:59:00.00

        wait_ticks(6000);
        chk("alarm_pre", 40'(alarm_hit), 40'd0);
        cyc(1);
        chk("rollover_12h", 40'({d_hr, d_min, d_sec, pm}), 40'({8'h12, 8'h00, 8'h00, 1'b0}));
        chk("alarm_rise", 40'(alarm_hit), 40'd1);
        fmt_24h = 1; cyc(1);
        chk("rollover_24h", 40'(d_hr), 40'h00);
        fmt_24h = 0;
        press(1);
        chk("alarm_left_clear", 40'(alarm_hit), 40'd0);

        press(0); press(0); press(3);     // alarm 00:01, time 00:00:00.00
        chk("alarm_0001", 40'({d_hr, d_min}), 40'h1201);
        press(0);
        wait_ticks(6000);
        cyc(1);
        chk("alarm2_rise", 40'({alarm_hit, d_min}), 40'({1'b1, 8'h01}));
        wait_ticks(6000);
        chk("alarm2_hold", 40'(alarm_hit), 40'd1);
        cyc(1);
        chk("alarm2_timeout", 40'({alarm_hit, d_min}), 40'({1'b0, 8'h02}));

        press(0); press(0); press_n(3, 2); // alarm 00:03, time 00:02:00.00
        press(0);
        wait_ticks(6000);
        cyc(1);
        chk("alarm3_rise", 40'(alarm_hit), 40'd1);
        rst = 1; cyc(1); rst = 0;
        chk("midrun_rst", 40'({mode, alarm_hit, tick_cs, d_hr, d_min, d_sec, d_csec}),
            40'({2'd1, 1'b0, 1'b0, 8'h12, 8'h00, 8'h00, 8'h00}));
        press(0);
        chk("midrun_rst_alarm", 40'({d_hr, d_min}), 40'h0600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
